// File: rtl/code_entry.sv
// Keypad code accumulator: debounces scanner strobes into key events and builds an N-digit BCD code (* clears, # submits).
// Latency: event sampled at edge k is visible in cycle k+1; after #, codigo/cant clear on edge k+1.
// Backpressure: none, one event per press; CODE_ENTRY_BACKSPACE_EN turns key 0xD into backspace.
module code_entry #(
  parameter int N_DIGITS       = 4,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            digito,
  input  logic                  cambio_digito,
  output logic [4*N_DIGITS-1:0] codigo,
  output logic [2:0]            cant,
  output logic                  tecla_ok,
  output logic                  codigo_listo,
  output logic                  error_codigo
);

  localparam int W    = 4 * N_DIGITS;
  localparam int RC_W = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [2:0]      CANT_FULL = 3'(N_DIGITS);
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RELEASE_CYCLES - 1);

  typedef enum logic {RELEASED, HELD} state_t;

  state_t          state, state_nxt;
  logic [RC_W-1:0] rc, rc_nxt;
  logic [W-1:0]    codigo_nxt, shifted;
  logic [2:0]      cant_nxt;
  logic            clr_pend, clr_nxt;
  logic            tecla_nxt, listo_nxt, err_nxt;
  logic            key_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HELD;
      rc           <= '0;
      codigo       <= '0;
      cant         <= '0;
      clr_pend     <= 1'b0;
      tecla_ok     <= 1'b0;
      codigo_listo <= 1'b0;
      error_codigo <= 1'b0;
    end else begin
      state        <= state_nxt;
      rc           <= rc_nxt;
      codigo       <= codigo_nxt;
      cant         <= cant_nxt;
      clr_pend     <= clr_nxt;
      tecla_ok     <= tecla_nxt;
      codigo_listo <= listo_nxt;
      error_codigo <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rc_nxt     = rc;
    codigo_nxt = codigo;
    cant_nxt   = cant;
    clr_nxt    = 1'b0;
    tecla_nxt  = 1'b0;
    listo_nxt  = 1'b0;
    err_nxt    = 1'b0;
    key_event  = 1'b0;
    shifted    = codigo << 4;
    shifted[3:0] = digito[3:0];

    // Any strobe while held restarts the release interval, so a key change mid-hold is ignored.
    case (state)
      RELEASED: begin
        if (cambio_digito) begin
          key_event = 1'b1;
          state_nxt = HELD;
          rc_nxt    = '0;
        end
      end
      HELD: begin
        if (cambio_digito) begin
          rc_nxt = '0;
        end else if (rc == RC_LAST) begin
          state_nxt = RELEASED;
          rc_nxt    = '0;
        end else begin
          rc_nxt = rc + RC_W'(1);
        end
      end
      default: begin
        state_nxt = HELD;
        rc_nxt    = '0;
      end
    endcase

    // Deferred clear after #, so codigo stays stable during the codigo_listo cycle.
    if (clr_pend) begin
      codigo_nxt = '0;
      cant_nxt   = '0;
    end

    if (key_event && !digito[4]) begin
      tecla_nxt = 1'b1;
      if (digito[3:0] <= 4'd9) begin
        if (cant < CANT_FULL) begin
          codigo_nxt = shifted;
          cant_nxt   = cant + 3'd1;
        end
      end else begin
        case (digito[3:0])
          4'hF: begin
            codigo_nxt = '0;
            cant_nxt   = '0;
          end
          4'hE: begin
            clr_nxt = 1'b1;
            if (cant == CANT_FULL) listo_nxt = 1'b1;
            else                   err_nxt   = 1'b1;
          end
`ifdef CODE_ENTRY_BACKSPACE_EN
          4'hD: begin
            if (cant != 3'd0) begin
              codigo_nxt = codigo >> 4;
              cant_nxt   = cant - 3'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
